imagine_outfifo: RTL and testbench
==================================

Name: imagine_outfifo

Overview:
- Output buffer directly downstream of the IMAGine top-level wrapper. It consumes the wrapper's vector dataout stream: dataout, dataAttrib, dataoutValid and eovInterrupt.
- The wrapper stream has no backpressure. This block absorbs it into a circular FIFO and re-presents it as a first-word-fall-through valid/ready stream, with an end-of-vector `last` flag.
- It drives clearEOV back into the wrapper once the end-of-vector word has been consumed downstream.
- It also reports fill level and sticky overflow.

Parameters:
- DATA_WIDTH, 16, width of dataout words; must match the wrapper DATAOUT_WIDTH.
- ATTRIB_WIDTH, 2, width of dataAttrib; must match the vector-shift status width.
- EOV_BIT, 0, index in dataAttrib that marks the end-of-vector word.
- DEPTH, 64, FIFO entries; power of two, at least 4.
- AFULL_THRESH, 56, level at or above which almostFull asserts.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- dataout  in  DATA_WIDTH  vector word from wrapper
- dataAttrib  in  ATTRIB_WIDTH  attributes of dataout
- dataoutValid  in  1  write strobe; no backpressure possible
- eovInterrupt  in  1  wrapper end-of-vector interrupt level
- clearEOV  out  1  one-cycle pulse to clear the wrapper interrupt
- m_data  out  DATA_WIDTH  head-of-FIFO word
- m_attrib  out  ATTRIB_WIDTH  head-of-FIFO attributes
- m_last  out  1  equals m_attrib[EOV_BIT] while m_valid is high
- m_valid  out  1  head entry valid
- m_ready  in  1  consumer accepts head
- level  out  $clog2(DEPTH)+1  current occupancy
- almostFull  out  1  level >= AFULL_THRESH
- overflow  out  1  sticky flag: a word was dropped
- dropCount  out  16  saturating count of dropped words
- overflowClear  in  1  synchronous clear of overflow and dropCount

Behaviour:
- Reset (resetn low, asynchronous): all outputs go to 0 immediately.
  - Cleared state: rd/wr pointers, level, flags, dropCount, and the eovArmed state.
  - Memory contents are don't-care.
  - Reset mid-transfer discards all buffered words. No clearEOV is issued for discarded words.
- Storage: DEPTH x (DATA_WIDTH+ATTRIB_WIDTH) array, read combinationally at rd pointer. Distributed RAM is acceptable.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- pop = m_valid & m_ready.
- push:
  - A push is accepted when dataoutValid and (level < DEPTH, or pop in the same cycle).
  - Simultaneous push and pop when full is accepted and level stays at DEPTH.
- level update: +1 on push only; -1 on pop only; unchanged on both or neither.
- m_valid = (level != 0); it is registered-state derived and has no combinational path from inputs.
- Latency: a word pushed at edge N is visible on m_data/m_valid after edge N. This gives one cycle write-to-read when the FIFO was empty.
- Read while empty: m_valid is 0, and m_ready is ignored.
- Drop:
  - A drop occurs on dataoutValid with level == DEPTH and no pop.
  - The word is discarded, overflow sets, and dropCount increments, saturating at 16'hFFFF.
- overflowClear:
  - overflowClear clears both overflow and dropCount.
  - If a drop occurs in the same cycle as overflowClear, the result is overflow=1 and dropCount=1.
- EOV / clearEOV handshake:
  - eovArmed sets on pop of a word with m_last=1.
  - In the cycle after arming, if eovInterrupt is 1: clearEOV pulses high for exactly one cycle and eovArmed clears.
  - If eovInterrupt is 0: eovArmed clears with no pulse.
  - Back-to-back m_last pops re-arm; each one yields at most one pulse, at most one pulse per cycle.
- almostFull is combinational from the level register.

Test Plan:
- Passthrough: m_ready=1; push 8 words 0x0001..0x0008, the last with attrib[0]=1 -> each word appears on m_data one cycle later; m_last is high only on 0x0008; level never exceeds 1.
- Fill and drop: m_ready=0; push 70 words -> level=64, almostFull rises at the 56th push, overflow=1, dropCount=6. Then drain -> words 1..64 in order, and wrap is correct.
- Full push+pop: hold level=64; in one cycle assert dataoutValid=1 with word 0xBEEF and m_ready=1 -> no drop, level stays 64, 0xBEEF is read last after draining.
- EOV clear: eovInterrupt=1; pop an m_last word -> clearEOV is high exactly one cycle, one cycle after the pop. Repeat with eovInterrupt=0 -> no pulse.
- Clear collision: with overflow set, assert overflowClear together with a drop -> overflow=1, dropCount=1.
- Reset mid-operation: level=20, deassert resetn for 1 cycle -> m_valid=0, level=0, overflow=0 asynchronously. Then push 0x1234 -> first output is 0x1234.

Source files
------------

// File: rtl/imagine_outfifo.sv
// Output FIFO behind the IMAGine wrapper: absorbs the unthrottled dataout stream and
// re-presents it as a first-word-fall-through valid/ready stream with end-of-vector handshake.
module imagine_outfifo #(
   parameter int DATA_WIDTH   = 16,
   parameter int ATTRIB_WIDTH = 2,
   parameter int EOV_BIT      = 0,
   parameter int DEPTH        = 64,
   parameter int AFULL_THRESH = 56
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [DATA_WIDTH-1:0]      dataout,
   input  logic [ATTRIB_WIDTH-1:0]    dataAttrib,
   input  logic                       dataoutValid,
   input  logic                       eovInterrupt,
   output logic                       clearEOV,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic [ATTRIB_WIDTH-1:0]    m_attrib,
   output logic                       m_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       almostFull,
   output logic                       overflow,
   output logic [15:0]                dropCount,
   input  logic                       overflowClear
);

   // state     | meaning
   // EOV_IDLE  | no end-of-vector word popped last cycle
   // EOV_ARMED | end-of-vector word popped last cycle; clear the wrapper if it still interrupts
   typedef enum logic {EOV_IDLE, EOV_ARMED} eovState_t;

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = DATA_WIDTH + ATTRIB_WIDTH;

   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  rdPtr;
   logic [AW-1:0]  wrPtr;
   logic [LW-1:0]  levelQ;
   logic [EW-1:0]  headWord;
   logic           full;
   logic           pop;
   logic           push;
   logic           drop;
   logic           overflowQ;
   logic [15:0]    dropCntQ;
   eovState_t      eovState;
   eovState_t      eovNext;

   assign full     = (levelQ == LW'(DEPTH));
   assign m_valid  = (levelQ != '0);
   assign pop      = m_valid & m_ready;
   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign push     = dataoutValid & (~full | pop);
   assign drop     = dataoutValid & full & ~pop;
   assign headWord = mem[rdPtr];

   // Head is forced to zero while empty so stale memory never leaks out after reset.
   assign m_data     = m_valid ? headWord[EW-1:ATTRIB_WIDTH] : '0;
   assign m_attrib   = m_valid ? headWord[ATTRIB_WIDTH-1:0]  : '0;
   assign m_last     = m_attrib[EOV_BIT];
   assign level      = levelQ;
   assign almostFull = (levelQ >= LW'(AFULL_THRESH));
   assign overflow   = overflowQ;
   assign dropCount  = dropCntQ;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= {dataout, dataAttrib};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         levelQ <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         case ({push, pop})
            2'b10:   levelQ <= levelQ + LW'(1);
            2'b01:   levelQ <= levelQ - LW'(1);
            default: levelQ <= levelQ;
         endcase
      end
   end

   // A drop coinciding with a clear is counted as the first drop after the clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflowQ <= 1'b0;
         dropCntQ  <= '0;
      end else if (overflowClear) begin
         overflowQ <= drop;
         dropCntQ  <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
         overflowQ <= 1'b1;
         if (dropCntQ != 16'hFFFF) begin
            dropCntQ <= dropCntQ + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         eovState <= EOV_IDLE;
      end else begin
         eovState <= eovNext;
      end
   end

   always_comb begin
      eovNext  = EOV_IDLE;
      clearEOV = 1'b0;
      case (eovState)
         EOV_ARMED: clearEOV = eovInterrupt;
         default:   clearEOV = 1'b0;
      endcase
      // Back-to-back last words re-arm while the previous one is being serviced.
      if (pop && m_last) begin
         eovNext = EOV_ARMED;
      end
   end

endmodule

// File: tb/tb_imagine_outfifo.sv
// Self-checking bench for imagine_outfifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_imagine_outfifo;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] dataout;
   logic [1:0]  dataAttrib;
   logic        dataoutValid;
   logic        eovInterrupt;
   logic        clearEOV;
   logic [15:0] m_data;
   logic [1:0]  m_attrib;
   logic        m_last;
   logic        m_valid;
   logic        m_ready;
   logic [6:0]  level;
   logic        almostFull;
   logic        overflow;
   logic [15:0] dropCount;
   logic        overflowClear;

   int passCnt = 0;
   int totalCnt = 0;

   logic [17:0] mq[$];
   bit          ovM;
   int          dropM;
   bit          armedM;

   typedef struct {
      bit          v;
      logic [15:0] d;
      logic [1:0]  a;
      bit          e;
      bit          r;
      bit          expValid;
      logic [15:0] expData;
      bit          expLast;
      logic [6:0]  expLevel;
      bit          expClr;
   } vec_t;

   vec_t tbl[11];

   imagine_outfifo dut (
      .clk(clk), .resetn(resetn), .dataout(dataout), .dataAttrib(dataAttrib),
      .dataoutValid(dataoutValid), .eovInterrupt(eovInterrupt), .clearEOV(clearEOV),
      .m_data(m_data), .m_attrib(m_attrib), .m_last(m_last), .m_valid(m_valid),
      .m_ready(m_ready), .level(level), .almostFull(almostFull), .overflow(overflow),
      .dropCount(dropCount), .overflowClear(overflowClear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic modelClear();
      mq.delete();
      ovM = 0;
      dropM = 0;
      armedM = 0;
   endtask

   // Drive one cycle of inputs at the falling edge, compare against the model, then
   // advance the model by the rising edge that follows.
   task automatic cycle(input bit v, input logic [15:0] d, input logic [1:0] a,
                        input bit e, input bit r, input bit oc);
      bit          expValid;
      bit          popM;
      bit          dropNow;
      logic [17:0] head;
      @(negedge clk);
      dataoutValid  = v;
      dataout       = d;
      dataAttrib    = a;
      eovInterrupt  = e;
      m_ready       = r;
      overflowClear = oc;
      #1;
      expValid = (mq.size() != 0);
      chk("m_valid", m_valid, expValid);
      chk("level", level, mq.size());
      chk("almostFull", almostFull, mq.size() >= 56);
      chk("overflow", overflow, ovM);
      chk("dropCount", dropCount, dropM);
      chk("clearEOV", clearEOV, armedM && e);
      head = '0;
      if (expValid) begin
         head = mq[0];
         chk("m_data", m_data, head[17:2]);
         chk("m_attrib", m_attrib, head[1:0]);
         chk("m_last", m_last, head[0]);
      end
      popM    = expValid && r;
      dropNow = v && (mq.size() == 64) && !popM;
      if (popM) void'(mq.pop_front());
      if (v && !dropNow) mq.push_back({d, a});
      if (oc) begin
         ovM   = dropNow;
         dropM = dropNow ? 1 : 0;
      end else if (dropNow) begin
         ovM = 1;
         if (dropM < 65535) dropM++;
      end
      armedM = popM && head[0];
   endtask

   task automatic idle(input bit r);
      cycle(1'b0, 16'h0, 2'b0, 1'b0, r, 1'b0);
   endtask

   task automatic doReset();
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rst m_valid", m_valid, 0);
      chk("rst level", level, 0);
      chk("rst overflow", overflow, 0);
      chk("rst dropCount", dropCount, 0);
      chk("rst m_data", m_data, 0);
      chk("rst clearEOV", clearEOV, 0);
      modelClear();
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      dataoutValid = 0; dataout = 0; dataAttrib = 0;
      eovInterrupt = 0; m_ready = 0; overflowClear = 0;
      modelClear();

      // Initial reset
      doReset();

      // Passthrough table: expected values are the state seen during each row, before its edge.
      for (int i = 0; i < 8; i++) begin
         tbl[i] = '{v: 1, d: 16'(i + 1), a: (i == 7) ? 2'b01 : 2'b00, e: 1, r: 1,
                    expValid: (i > 0), expData: 16'(i), expLast: 0,
                    expLevel: (i > 0) ? 7'd1 : 7'd0, expClr: 0};
      end
      tbl[8]  = '{v: 0, d: 0, a: 0, e: 1, r: 1, expValid: 1, expData: 16'h0008, expLast: 1,
                  expLevel: 1, expClr: 0};
      tbl[9]  = '{v: 0, d: 0, a: 0, e: 1, r: 1, expValid: 0, expData: 0, expLast: 0,
                  expLevel: 0, expClr: 1};
      tbl[10] = '{v: 0, d: 0, a: 0, e: 1, r: 1, expValid: 0, expData: 0, expLast: 0,
                  expLevel: 0, expClr: 0};
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].e, tbl[i].r, 1'b0);
         chk($sformatf("tbl%0d m_valid", i), m_valid, tbl[i].expValid);
         chk($sformatf("tbl%0d level", i), level, tbl[i].expLevel);
         chk($sformatf("tbl%0d clearEOV", i), clearEOV, tbl[i].expClr);
         if (tbl[i].expValid) begin
            chk($sformatf("tbl%0d m_data", i), m_data, tbl[i].expData);
            chk($sformatf("tbl%0d m_last", i), m_last, tbl[i].expLast);
         end
      end

      // EOV with interrupt already low: the arm must expire without a late pulse.
      cycle(1'b1, 16'h00AA, 2'b01, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 2'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 16'h0, 2'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 2'b0, 1'b1, 1'b0, 1'b0);
      chk("eov late pulse", clearEOV, 0);

      // Fill and drop
      for (int i = 1; i <= 70; i++) begin
         cycle(1'b1, 16'(i), 2'b00, 1'b0, 1'b0, 1'b0);
         if (i == 56) chk("almostFull before 56th", almostFull, 0);
         if (i == 57) chk("almostFull after 56th", almostFull, 1);
      end
      idle(1'b0);
      chk("fill level", level, 64);
      chk("fill overflow", overflow, 1);
      chk("fill dropCount", dropCount, 6);

      // Push and pop together while full
      cycle(1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      chk("full push+pop level", level, 64);
      chk("full push+pop dropCount", dropCount, 6);
      chk("full push+pop head", m_data, 16'h0002);
      for (int i = 0; i < 64; i++) idle(1'b1);
      chk("drain tail", m_data, 16'hBEEF);
      idle(1'b1);
      chk("drain level", level, 0);

      // Clear colliding with a drop
      for (int i = 0; i < 65; i++) cycle(1'b1, 16'(16'h0100 + i), 2'b10, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'hDEAD, 2'b00, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      chk("collision overflow", overflow, 1);
      chk("collision dropCount", dropCount, 1);
      cycle(1'b0, 16'h0, 2'b0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      chk("clear overflow", overflow, 0);
      chk("clear dropCount", dropCount, 0);

      // Reset mid-operation
      doReset();
      for (int i = 0; i < 20; i++) cycle(1'b1, 16'(16'h0200 + i), 2'b01, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      chk("pre-reset level", level, 20);
      resetn = 1'b0;
      #1;
      chk("async rst m_valid", m_valid, 0);
      chk("async rst level", level, 0);
      chk("async rst overflow", overflow, 0);
      modelClear();
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      cycle(1'b1, 16'h1234, 2'b00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 2'b0, 1'b1, 1'b1, 1'b0);
      chk("post-reset first word", m_data, 16'h1234);
      idle(1'b1);
      chk("post-reset no clearEOV", clearEOV, 0);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         int  ph;
         bit  r;
         ph = (k / 200) % 3;
         case (ph)
            0:       r = ($urandom_range(9, 0) < 2);
            1:       r = ($urandom_range(9, 0) < 9);
            default: r = ($urandom_range(9, 0) < 5);
         endcase
         cycle($urandom_range(9, 0) < 7, 16'($urandom), 2'($urandom),
               $urandom_range(3, 0) != 0, r, $urandom_range(49, 0) == 0);
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
